// File: rtl/adder_selftest_driver.sv
// Built-in self-test initiator for a registered nibble adder: sweeps all 256
// packed operand pairs, checks each result and records the first failure.
module adder_selftest_driver #(
   parameter int LATENCY     = 1,
   parameter int ERR_W       = 8,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       res_in,
   output logic [7:0]       op_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_vec,
   output logic [7:0]       fail_res
);

   localparam int WC_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t           r_state, w_state_next;
   logic [7:0]       r_vec, w_vec_next;
   logic [WC_W-1:0]  r_wait_cnt, w_wait_cnt_next;
   logic [7:0]       r_op, w_op_next;
   logic             r_busy, w_busy_next;
   logic             r_done, w_done_next;
   logic             r_pass, w_pass_next;
   logic [ERR_W-1:0] r_err_count, w_err_count_next;
   logic [7:0]       r_fail_vec, w_fail_vec_next;
   logic [7:0]       r_fail_res, w_fail_res_next;

   logic [3:0]       w_sum;
   logic [7:0]       w_expected;
   logic             w_mismatch;
   logic             w_last;
   logic             w_wait_done;
   logic             w_start_ok;

   // Expected result keeps only the wrapped nibble; the upper nibble must be zero.
   assign w_sum       = r_vec[7:4] + r_vec[3:0];
   assign w_expected  = {4'h0, w_sum};
   assign w_mismatch  = (res_in != w_expected);
   assign w_last      = (r_vec == 8'hFF) || (STOP_ON_ERR && w_mismatch);
   assign w_wait_done = (r_wait_cnt == WC_W'(LATENCY - 1));
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_vec       <= '0;
         r_wait_cnt  <= '0;
         r_op        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_count <= '0;
         r_fail_vec  <= '0;
         r_fail_res  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_vec       <= w_vec_next;
         r_wait_cnt  <= w_wait_cnt_next;
         r_op        <= w_op_next;
         r_busy      <= w_busy_next;
         r_done      <= w_done_next;
         r_pass      <= w_pass_next;
         r_err_count <= w_err_count_next;
         r_fail_vec  <= w_fail_vec_next;
         r_fail_res  <= w_fail_res_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_WAIT;
         S_WAIT:  if (w_wait_done) w_state_next = S_CHECK;
         S_CHECK: w_state_next = w_last ? S_DONE : S_WAIT;
         S_DONE:  if (start) w_state_next = S_WAIT;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_vec_next       = r_vec;
      w_wait_cnt_next  = r_wait_cnt;
      w_op_next        = r_op;
      w_busy_next      = r_busy;
      w_done_next      = r_done;
      w_pass_next      = r_pass;
      w_err_count_next = r_err_count;
      w_fail_vec_next  = r_fail_vec;
      w_fail_res_next  = r_fail_res;

      if (w_start_ok) begin
         w_vec_next       = '0;
         w_wait_cnt_next  = '0;
         w_op_next        = '0;
         w_busy_next      = 1'b1;
         w_done_next      = 1'b0;
         w_pass_next      = 1'b0;
         w_err_count_next = '0;
         w_fail_vec_next  = '0;
         w_fail_res_next  = '0;
      end else if (r_state == S_WAIT) begin
         w_wait_cnt_next = r_wait_cnt + WC_W'(1);
      end else if (r_state == S_CHECK) begin
         if (w_mismatch) begin
            if (r_err_count != '1)
               w_err_count_next = r_err_count + ERR_W'(1);
            // Only the first mismatch of a sweep is recorded.
            if (r_err_count == '0) begin
               w_fail_vec_next = r_vec;
               w_fail_res_next = res_in;
            end
         end
         if (w_last) begin
            w_busy_next = 1'b0;
            w_done_next = 1'b1;
            w_pass_next = (w_err_count_next == '0);
         end else begin
            w_vec_next      = r_vec + 8'd1;
            w_op_next       = r_vec + 8'd1;
            w_wait_cnt_next = '0;
         end
      end
   end

   assign op_out    = r_op;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err_count;
   assign fail_vec  = r_fail_vec;
   assign fail_res  = r_fail_res;

endmodule

// File: tb/tb_adder_selftest_driver.sv
// Directed bench for adder_selftest_driver with behavioural adder models
// (golden, stuck bit, missing wrap, stuck-high bus) behind each instance.
module tb_adder_selftest_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         mode;          // adder model behind the main instance

   // main instance: LATENCY=1, full sweep
   logic       start_m;
   logic [7:0] res_m, op_m, fv_m, fr_m, ec_m;
   logic       busy_m, done_m, pass_m;

   // stop-on-error instance with a no-wrap adder
   logic       start_s;
   logic [7:0] res_s, op_s, fv_s, fr_s, ec_s;
   logic       busy_s, done_s, pass_s;

   // LATENCY=3 instance with a golden three-stage adder
   logic       start_l;
   logic [7:0] res_l, op_l, fv_l, fr_l, ec_l;
   logic       busy_l, done_l, pass_l;
   logic [7:0] pipe_l1, pipe_l2;

   adder_selftest_driver #(.LATENCY(1), .ERR_W(8), .STOP_ON_ERR(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_m), .res_in(res_m), .op_out(op_m),
      .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(ec_m),
      .fail_vec(fv_m), .fail_res(fr_m));

   adder_selftest_driver #(.LATENCY(1), .ERR_W(8), .STOP_ON_ERR(1'b1)) dut_stop (
      .clk(clk), .rst_n(rst_n), .start(start_s), .res_in(res_s), .op_out(op_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(ec_s),
      .fail_vec(fv_s), .fail_res(fr_s));

   adder_selftest_driver #(.LATENCY(3), .ERR_W(8), .STOP_ON_ERR(1'b0)) dut_l3 (
      .clk(clk), .rst_n(rst_n), .start(start_l), .res_in(res_l), .op_out(op_l),
      .busy(busy_l), .done(done_l), .pass(pass_l), .err_count(ec_l),
      .fail_vec(fv_l), .fail_res(fr_l));

   function automatic logic [7:0] golden(input logic [7:0] op);
      logic [3:0] s;
      s = op[7:4] + op[3:0];
      return {4'h0, s};
   endfunction

   function automatic logic [7:0] nowrap(input logic [7:0] op);
      logic [4:0] s;
      s = {1'b0, op[7:4]} + {1'b0, op[3:0]};
      return {3'b000, s};
   endfunction

   always @(posedge clk) begin
      case (mode)
         1:       res_m <= golden(op_m) & 8'hFE;
         2:       res_m <= 8'hFF;
         default: res_m <= golden(op_m);
      endcase
      res_s   <= nowrap(op_s);
      pipe_l1 <= golden(op_l);
      pipe_l2 <= pipe_l1;
      res_l   <= pipe_l2;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_done(input int which);
      case (which)
         1:       return done_s;
         2:       return done_l;
         default: return done_m;
      endcase
   endfunction

   // Leaves the caller at the falling edge just after the start edge.
   task automatic pulse_start(input int which);
      @(negedge clk);
      case (which)
         1:       start_s = 1'b1;
         2:       start_l = 1'b1;
         default: start_m = 1'b1;
      endcase
      @(negedge clk);
      start_m = 1'b0; start_s = 1'b0; start_l = 1'b0;
   endtask

   // cyc = number of edges after the start edge until done is seen.
   task automatic wait_done(input int which, input int limit, output int cyc);
      cyc = 0;
      while (!sel_done(which) && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_op"},   op_m,   8'h00);
      check({tag, "_busy"}, busy_m, 1'b0);
      check({tag, "_done"}, done_m, 1'b0);
      check({tag, "_pass"}, pass_m, 1'b0);
      check({tag, "_err"},  ec_m,   8'h00);
      check({tag, "_fvec"}, fv_m,   8'h00);
      check({tag, "_fres"}, fr_m,   8'h00);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; mode = 0;
      start_m = 1'b0; start_s = 1'b0; start_l = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      check("reset_busy_s", busy_s, 1'b0);
      rst_n = 1'b1;

      // 1: golden sweep
      pulse_start(0);
      check("t1_busy0", busy_m, 1'b1);
      check("t1_op0",   op_m,   8'h00);
      @(negedge clk);
      check("t1_op_e1", op_m, 8'h00);
      @(negedge clk);
      check("t1_op_e2", op_m, 8'h01);
      cyc = 2;
      while (!done_m && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      $display("[TB] golden sweep: cycles=%0d err=%0d pass=%0d", cyc, ec_m, pass_m);
      check("t1_cycles", cyc,    512);
      check("t1_busy",   busy_m, 1'b0);
      check("t1_pass",   pass_m, 1'b1);
      check("t1_err",    ec_m,   8'd0);
      check("t1_fvec",   fv_m,   8'h00);
      check("t1_fres",   fr_m,   8'h00);
      check("t1_op_hold", op_m,  8'hFF);

      // 2: res_in[0] stuck low, restarted from DONE
      mode = 1;
      pulse_start(0);
      check("t2_done_clr", done_m, 1'b0);
      wait_done(0, 2000, cyc);
      $display("[TB] stuck-bit sweep: cycles=%0d err=%0d fvec=%0h", cyc, ec_m, fv_m);
      check("t2_cycles", cyc,    512);
      check("t2_err",    ec_m,   8'd128);
      check("t2_fvec",   fv_m,   8'h01);
      check("t2_fres",   fr_m,   8'h00);
      check("t2_pass",   pass_m, 1'b0);

      // 4: result bus stuck at 0xFF, error counter saturates
      mode = 2;
      pulse_start(0);
      wait_done(0, 2000, cyc);
      $display("[TB] stuck-high sweep: cycles=%0d err=%0d", cyc, ec_m);
      check("t4_err",  ec_m,   8'd255);
      check("t4_fvec", fv_m,   8'h00);
      check("t4_fres", fr_m,   8'hFF);
      check("t4_pass", pass_m, 1'b0);

      // 5: start while busy is ignored
      mode = 0;
      pulse_start(0);
      cyc = 0;
      while (!done_m && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 128) begin
            check("t5_op40", op_m, 8'h40);
            start_m = 1'b1;
         end
         if (cyc == 129) start_m = 1'b0;
      end
      $display("[TB] busy-start sweep: cycles=%0d err=%0d pass=%0d", cyc, ec_m, pass_m);
      check("t5_cycles", cyc,    512);
      check("t5_err",    ec_m,   8'd0);
      check("t5_pass",   pass_m, 1'b1);

      // 6: reset mid-sweep, then a clean sweep
      mode = 1;
      pulse_start(0);
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero("t6_rst");
      @(negedge clk);
      check("t6_idle_op", op_m, 8'h00);
      mode = 0;
      pulse_start(0);
      wait_done(0, 2000, cyc);
      $display("[TB] post-reset sweep: cycles=%0d err=%0d pass=%0d", cyc, ec_m, pass_m);
      check("t6_cycles", cyc,    512);
      check("t6_pass",   pass_m, 1'b1);
      check("t6_err",    ec_m,   8'd0);

      // 3: stop at first error with a no-wrap adder
      pulse_start(1);
      wait_done(1, 2000, cyc);
      $display("[TB] stop-on-error sweep: cycles=%0d err=%0d fvec=%0h fres=%0h", cyc, ec_s, fv_s, fr_s);
      check("t3_cycles", cyc,    64);
      check("t3_fvec",   fv_s,   8'h1F);
      check("t3_fres",   fr_s,   8'h10);
      check("t3_err",    ec_s,   8'd1);
      check("t3_pass",   pass_s, 1'b0);
      check("t3_busy",   busy_s, 1'b0);
      check("t3_op",     op_s,   8'h1F);

      // LATENCY=3 golden sweep: four cycles per vector
      pulse_start(2);
      wait_done(2, 3000, cyc);
      $display("[TB] latency-3 sweep: cycles=%0d err=%0d pass=%0d", cyc, ec_l, pass_l);
      check("l3_cycles", cyc,    1024);
      check("l3_pass",   pass_l, 1'b1);
      check("l3_err",    ec_l,   8'd0);
      check("l3_op",     op_l,   8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
